// File: rtl/clip_serializer.sv
// Clip playback reader: fetches one block of clip memory sample by sample and
// shifts each sample out MSB-first on bit_tick. Optional even-parity bit per
// sample when CLIP_SERIALIZER_PARITY_EN is defined.
module clip_serializer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned CLIP_LEN = 16000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              seriena,
    input  logic              clipsel,
    input  logic              bit_tick,
    output logic              rd_en,
    output logic [ADDR_W:0]   rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              serial_out,
    output logic              frame,
    output logic              busy,
    output logic              done
);

`ifdef CLIP_SERIALIZER_PARITY_EN
    localparam int unsigned FRAME_W = DATA_W + 1;
`else
    localparam int unsigned FRAME_W = DATA_W;
`endif
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CLIP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_HOLD
    } state_e;

    state_e              state_q;
    logic                blk_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [CNT_W-1:0]    bitcnt_q;
    logic [FRAME_W-1:0]  shreg_q;
    logic                rd_en_q;
    logic [ADDR_W:0]     rd_addr_q;
    logic                serial_out_q;
    logic                frame_q;
    logic                busy_q;
    logic                done_q;

    logic [FRAME_W-1:0]  load_bits_c;
    logic                abort_c;

    // Frame contents captured from memory, with the parity bit appended when enabled.
`ifdef CLIP_SERIALIZER_PARITY_EN
    assign load_bits_c = {rd_data, ^rd_data};
`else
    assign load_bits_c = rd_data;
`endif

    assign abort_c = !seriena &&
                     (state_q == S_FETCH || state_q == S_LOAD || state_q == S_SHIFT);

    // Playback FSM; serial_out is updated alongside the shift so the LSB holds through the fetch gap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            blk_q        <= 1'b0;
            idx_q        <= '0;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            serial_out_q <= 1'b0;
            frame_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (abort_c) begin
                state_q      <= S_IDLE;
                serial_out_q <= 1'b0;
                frame_q      <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (seriena) begin
                            blk_q     <= clipsel;
                            idx_q     <= '0;
                            bitcnt_q  <= '0;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= {clipsel, ADDR_W'(0)};
                            busy_q    <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        state_q <= S_LOAD;
                    end
                    S_LOAD: begin
                        shreg_q      <= load_bits_c;
                        bitcnt_q     <= '0;
                        serial_out_q <= load_bits_c[FRAME_W-1];
                        frame_q      <= 1'b1;
                        state_q      <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (bit_tick) begin
                            shreg_q  <= shreg_q << 1;
                            bitcnt_q <= bitcnt_q + CNT_W'(1);
                            frame_q  <= 1'b0;
                            if (bitcnt_q == LAST_BIT) begin
                                if (idx_q == LAST_IDX) begin
                                    done_q       <= 1'b1;
                                    busy_q       <= 1'b0;
                                    serial_out_q <= 1'b0;
                                    state_q      <= S_HOLD;
                                end else begin
                                    idx_q     <= idx_q + ADDR_W'(1);
                                    rd_en_q   <= 1'b1;
                                    rd_addr_q <= {blk_q, idx_q + ADDR_W'(1)};
                                    state_q   <= S_FETCH;
                                end
                            end else begin
                                serial_out_q <= shreg_q[FRAME_W-2];
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!seriena) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign serial_out = serial_out_q;
    assign frame      = frame_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_clip_serializer.sv
// Directed bench for clip_serializer: reset, both blocks, abort, held enable,
// reset priority; expected streams follow CLIP_SERIALIZER_PARITY_EN.
module tb_clip_serializer;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned CLIP_LEN = 4;
`ifdef CLIP_SERIALIZER_PARITY_EN
    localparam int unsigned FW = DATA_W + 1;
    localparam logic [4*FW-1:0] STREAM_B1 = 36'b101001010_001111000_111111110_000000011;
    localparam logic [4*FW-1:0] STREAM_B2 = 36'b010110100_110000110_000000000_100000001;
`else
    localparam int unsigned FW = DATA_W;
    localparam logic [4*FW-1:0] STREAM_B1 = 32'b10100101_00111100_11111111_00000001;
    localparam logic [4*FW-1:0] STREAM_B2 = 32'b01011010_11000011_00000000_10000000;
`endif

    logic              clock;
    logic              reset;
    logic              seriena;
    logic              clipsel;
    logic              bit_tick;
    logic              rd_en;
    logic [ADDR_W:0]   rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              serial_out;
    logic              frame;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [16];
    int                n_tests;
    int                n_fail;
    int                done_cnt;
    int                rd_cnt;

    clip_serializer #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .CLIP_LEN(CLIP_LEN)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .seriena   (seriena),
        .clipsel   (clipsel),
        .bit_tick  (bit_tick),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .serial_out(serial_out),
        .frame     (frame),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Clip memory: data valid the cycle after rd_en.
    always @(posedge clock) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Pulse counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (done)  done_cnt <= done_cnt + 1;
        if (rd_en) rd_cnt   <= rd_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check_eq({tag, "_serial"}, 32'(serial_out), 32'd0);
        check_eq({tag, "_frame"}, 32'(frame), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Plays one clip with ticks every 4 clocks, checking every bit; abort_at>0 drops seriena on that tick.
    task automatic play(input logic blk, input bit toggle, input int abort_at,
                        input logic [4*FW-1:0] stream);
        int t;
        int d0;
        logic exp_bit;
        t  = 0;
        d0 = done_cnt;
        clipsel = blk;
        seriena = 1'b1;
        step();
        check_eq("start_rd_en", 32'(rd_en), 32'd1);
        check_eq("start_addr", 32'(rd_addr), 32'({blk, ADDR_W'(0)}));
        check_eq("start_busy", 32'(busy), 32'd1);
        step();
        check_eq("load_rd_en", 32'(rd_en), 32'd0);
        step();
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < int'(FW); b++) begin
                exp_bit = stream[4*FW-1-(s*FW+b)];
                check_eq("bit", 32'(serial_out), 32'(exp_bit));
                check_eq("frame", 32'(frame), 32'(b == 0));
                check_eq("busy", 32'(busy), 32'd1);
                t++;
                bit_tick = 1'b1;
                if (t == abort_at) seriena = 1'b0;
                if (toggle) clipsel = ~clipsel;
                step();
                bit_tick = 1'b0;
                if (t == abort_at) begin
                    check_idle_outputs("abort");
                    repeat (10) step();
                    check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
                    return;
                end
                if (b == int'(FW) - 1 && s == 3) begin
                    check_eq("done_pulse", 32'(done), 32'd1);
                    check_eq("done_busy", 32'(busy), 32'd0);
                    check_eq("done_serial", 32'(serial_out), 32'd0);
                    step();
                    check_eq("done_fall", 32'(done), 32'd0);
                    check_eq("done_count", 32'(done_cnt - d0), 32'd1);
                end else if (b == int'(FW) - 1) begin
                    check_eq("gap_rd_en", 32'(rd_en), 32'd1);
                    check_eq("gap_addr", 32'(rd_addr), 32'({blk, ADDR_W'(s + 1)}));
                    check_eq("gap_hold", 32'(serial_out), 32'(exp_bit));
                    check_eq("gap_frame", 32'(frame), 32'd0);
                    repeat (3) step();
                end else begin
                    repeat (3) step();
                end
            end
        end
    endtask

    initial begin
        int d_rd;
        int d_done;
        n_tests  = 0;
        n_fail   = 0;
        done_cnt = 0;
        rd_cnt   = 0;
        rd_data  = '0;
        reset    = 1'b1;
        seriena  = 1'b1;
        clipsel  = 1'b0;
        bit_tick = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0]  = 8'hA5; mem[1]  = 8'h3C; mem[2]  = 8'hFF; mem[3]  = 8'h01;
        mem[8]  = 8'h5A; mem[9]  = 8'hC3; mem[10] = 8'h00; mem[11] = 8'h80;

        // Reset held two cycles with enable high.
        repeat (2) begin
            step();
            check_idle_outputs("reset");
            check_eq("reset_addr", 32'(rd_addr), 32'd0);
        end
        reset = 1'b0;

        // Block 1, starting on the first cycle out of reset.
        play(1'b0, 1'b0, 0, STREAM_B1);

        // Enable held after done: no replay.
        d_rd   = rd_cnt;
        d_done = done_cnt;
        repeat (200) step();
        check_eq("hold_no_rd", 32'(rd_cnt - d_rd), 32'd0);
        check_eq("hold_no_done", 32'(done_cnt - d_done), 32'd0);
        check_idle_outputs("hold");
        seriena = 1'b0;
        step();
        check_idle_outputs("hold_exit");

        // Block 2 with clipsel toggling every tick.
        play(1'b1, 1'b1, 0, STREAM_B2);
        seriena = 1'b0;
        step();

        // Abort on tick 13.
        play(1'b0, 1'b0, 13, STREAM_B1);

        // Reset wins mid-playback.
        clipsel = 1'b1;
        seriena = 1'b1;
        repeat (5) step();
        check_eq("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        check_idle_outputs("mid_reset");
        check_eq("mid_reset_addr", 32'(rd_addr), 32'd0);
        reset   = 1'b0;
        seriena = 1'b0;
        step();
        check_idle_outputs("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
